// File: rtl/dance_vga_pkg.sv
// Shared VGA frame-buffer constants, sprite indices and blitter state type
// for the dance game video path (160x120, 3-bit colour).
package dance_vga_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;

   // Colour bits are {R,G,B}, matching the adapter's 3-bit palette.
   localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
   localparam logic [COLOUR_W-1:0] BLUE    = 3'b001;
   localparam logic [COLOUR_W-1:0] GREEN   = 3'b010;
   localparam logic [COLOUR_W-1:0] CYAN    = 3'b011;
   localparam logic [COLOUR_W-1:0] RED     = 3'b100;
   localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
   localparam logic [COLOUR_W-1:0] YELLOW  = 3'b110;
   localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;

   localparam int ARROW_L = 0;
   localparam int ARROW_U = 1;
   localparam int ARROW_D = 2;
   localparam int ARROW_R = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAW  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } blit_state_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Request/status, sprite ROM and VGA adapter signals of the sprite blitter.
// The erase input exists only when SPRITE_BLITTER_ERASE_EN is defined.
interface sprite_blitter_if #(
   parameter int SPR_W   = 16,
   parameter int SPR_H   = 16,
   parameter int NUM_SPR = 4
);
   import dance_vga_pkg::*;

   localparam int SEL_W  = $clog2(NUM_SPR);
   localparam int ADDR_W = $clog2(NUM_SPR * SPR_W * SPR_H);

   logic                start;
   logic [SEL_W-1:0]    sel;
   logic [X_W-1:0]      x0;
   logic [Y_W-1:0]      y0;
`ifdef SPRITE_BLITTER_ERASE_EN
   logic                erase;
`endif
   logic [ADDR_W-1:0]   rom_addr;
   logic [COLOUR_W-1:0] rom_data;
   logic [X_W-1:0]      VGA_X;
   logic [Y_W-1:0]      VGA_Y;
   logic [COLOUR_W-1:0] VGA_COLOR;
   logic                plot;
   logic                busy;
   logic                done;

   modport master (
`ifdef SPRITE_BLITTER_ERASE_EN
      input  erase,
`endif
      input  start, sel, x0, y0, rom_data,
      output rom_addr, VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
   );

   modport slave (
`ifdef SPRITE_BLITTER_ERASE_EN
      output erase,
`endif
      output start, sel, x0, y0, rom_data,
      input  rom_addr, VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
   );

endinterface

// File: rtl/blit_raster_counter.sv
// Row-major col/row raster counter over one sprite, with a last-pixel flag
// and the linear pixel index row*SPR_W + col.
module blit_raster_counter #(
   parameter int SPR_W = 16,
   parameter int SPR_H = 16
) (
   input  logic                              clk_sys,
   input  logic                              rst_b,
   input  logic                              clear,
   input  logic                              advance,
   output logic [$clog2(SPR_W)-1:0]          col,
   output logic [$clog2(SPR_H)-1:0]          row,
   output logic                              last,
   output logic [$clog2(SPR_W*SPR_H)-1:0]    index
);
   localparam int COL_W = $clog2(SPR_W);
   localparam int ROW_W = $clog2(SPR_H);
   localparam int IDX_W = $clog2(SPR_W * SPR_H);

   logic col_wrap;

   assign col_wrap = (col == COL_W'(SPR_W - 1));
   assign last     = col_wrap && (row == ROW_W'(SPR_H - 1));
   assign index    = IDX_W'(row) * IDX_W'(SPR_W) + IDX_W'(col);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         col <= '0;
         row <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
      end else if (advance) begin
         if (col_wrap) begin
            col <= '0;
            row <= row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: rasters one sprite from a synchronous ROM to the VGA adapter
// with transparency and screen-edge clipping. SPRITE_BLITTER_ERASE_EN adds erase mode.
//
// state    | meaning
// ST_IDLE  | waiting for start (ignored while the done pulse is high)
// ST_DRAW  | issuing one ROM address per cycle, row-major
// ST_FLUSH | last address issued, ROM/pixel pipeline draining
// ST_DONE  | last pixel out; next edge drops busy and pulses done
module sprite_blitter
   import dance_vga_pkg::*;
#(
   parameter int                  SPR_W       = 16,
   parameter int                  SPR_H       = 16,
   parameter int                  NUM_SPR     = 4,
   parameter logic [COLOUR_W-1:0] TRANSPARENT = BLACK
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   sprite_blitter_if.master bus
);
   localparam int N      = SPR_W * SPR_H;
   localparam int COL_W  = $clog2(SPR_W);
   localparam int ROW_W  = $clog2(SPR_H);
   localparam int IDX_W  = $clog2(N);
   localparam int ADDR_W = $clog2(NUM_SPR * N);

   blit_state_t         state;
   logic [ADDR_W-1:0]   base_q;
   logic [X_W-1:0]      x0_q;
   logic [Y_W-1:0]      y0_q;
   logic                erase_q;
   logic                busy_q;
   logic                done_q;
   logic                accept;
   logic                advance;

   logic [COL_W-1:0]    col;
   logic [ROW_W-1:0]    row;
   logic                last;
   logic [IDX_W-1:0]    index;

   logic                s1_valid;
   logic [COL_W-1:0]    s1_col;
   logic [ROW_W-1:0]    s1_row;

   logic [8:0]          px;
   logic [7:0]          py;
   logic                in_bounds;
   logic                paint;
   logic [COLOUR_W-1:0] paint_colour;

   logic [X_W-1:0]      vga_x_q;
   logic [Y_W-1:0]      vga_y_q;
   logic [COLOUR_W-1:0] vga_colour_q;
   logic                plot_q;

   // The done cycle is already IDLE, so it must not double as an accept cycle.
   assign accept  = (state == ST_IDLE) && bus.start && !done_q;
   assign advance = (state == ST_DRAW) && !last;

   blit_raster_counter #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
   ) u_counter (
      .clk_sys (CLOCK_50),
      .rst_b   (resetn),
      .clear   (accept),
      .advance (advance),
      .col     (col),
      .row     (row),
      .last    (last),
      .index   (index)
   );

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         base_q  <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         erase_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state  <= ST_DRAW;
                  base_q <= ADDR_W'(bus.sel) * ADDR_W'(N);
                  x0_q   <= bus.x0;
                  y0_q   <= bus.y0;
`ifdef SPRITE_BLITTER_ERASE_EN
                  erase_q <= bus.erase;
`else
                  erase_q <= 1'b0;
`endif
                  busy_q <= 1'b1;
               end
            end
            ST_DRAW:  if (last) state <= ST_FLUSH;
            ST_FLUSH: state <= ST_DONE;
            ST_DONE: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Stage 1: position of the address in flight, aligned with rom_data next cycle.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_col   <= '0;
         s1_row   <= '0;
      end else begin
         s1_valid <= (state == ST_DRAW);
         s1_col   <= col;
         s1_row   <= row;
      end
   end

   assign px        = {1'b0, x0_q} + 9'(s1_col);
   assign py        = {1'b0, y0_q} + 8'(s1_row);
   assign in_bounds = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));

   always_comb begin
      paint        = 1'b0;
      paint_colour = bus.rom_data;
      if (erase_q) begin
         paint        = s1_valid && in_bounds;
         paint_colour = BLACK;
      end else begin
         paint = s1_valid && in_bounds && (bus.rom_data != TRANSPARENT);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         plot_q       <= 1'b0;
      end else begin
         plot_q <= paint;
         if (paint) begin
            vga_x_q      <= px[X_W-1:0];
            vga_y_q      <= py[Y_W-1:0];
            vga_colour_q <= paint_colour;
         end
      end
   end

   assign bus.rom_addr  = base_q + ADDR_W'(index);
   assign bus.VGA_X     = vga_x_q;
   assign bus.VGA_Y     = vga_y_q;
   assign bus.VGA_COLOR = vga_colour_q;
   assign bus.plot      = plot_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: 16x16 and 2x2 instances against a
// pixel-list reference model; erase scenario added when SPRITE_BLITTER_ERASE_EN is set.
module tb_sprite_blitter;
   import dance_vga_pkg::*;

   localparam int W     = 16;
   localparam int H     = 16;
   localparam int NS    = 4;
   localparam int N     = W * H;
   localparam int DEPTH = NS * N;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [2:0] rom  [DEPTH];
   logic [2:0] rom2 [16];

   // Last plotted pixel as the adapter should still see it.
   int ex = 0, ey = 0, ec = 0;

   sprite_blitter_if #(.SPR_W(W), .SPR_H(H), .NUM_SPR(NS)) bus ();
   sprite_blitter_if #(.SPR_W(2), .SPR_H(2), .NUM_SPR(NS)) bus2 ();

   sprite_blitter #(.SPR_W(W), .SPR_H(H), .NUM_SPR(NS), .TRANSPARENT(BLACK)) dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .bus      (bus)
   );

   sprite_blitter #(.SPR_W(2), .SPR_H(2), .NUM_SPR(NS), .TRANSPARENT(BLACK)) dut2 (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .bus      (bus2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bus.rom_data  <= rom[bus.rom_addr];
      bus2.rom_data <= rom2[bus2.rom_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one blit on the 16x16 instance; start is sampled on the next edge (k).
   task automatic run_blit(input string name, input int s, input int xs, input int ys,
                           input bit er, input bit poke, output int plots, output int busy_cyc);
      int  i, col, row, px, py, c;
      bit  vis, exp_busy, exp_done, exp_plot;
      plots    = 0;
      busy_cyc = 0;
      bus.start = 1'b1;
      bus.sel   = 2'(s);
      bus.x0    = 8'(xs);
      bus.y0    = 7'(ys);
`ifdef SPRITE_BLITTER_ERASE_EN
      bus.erase = er;
`endif
      tick();
      bus.start = 1'b0;
      bus.sel   = 2'($urandom);
      bus.x0    = 8'($urandom);
      bus.y0    = 7'($urandom);
`ifdef SPRITE_BLITTER_ERASE_EN
      bus.erase = 1'($urandom);
`endif
      for (int j = 0; j <= N + 3; j++) begin
         if (j > 0) tick();
         exp_busy = (j <= N + 1);
         exp_done = (j == N + 2);
         exp_plot = 1'b0;
         if (j >= 2 && j <= N + 1) begin
            i   = j - 2;
            col = i % W;
            row = i / W;
            px  = xs + col;
            py  = ys + row;
            c   = int'(rom[(s * N + i) % DEPTH]);
            vis = (er || c != 0) && px < SCREEN_W && py < SCREEN_H;
            if (vis) begin
               exp_plot = 1'b1;
               ex = px;
               ey = py;
               ec = er ? 0 : c;
            end
         end
         checks++;
         if ({bus.busy, bus.done, bus.plot} !== {exp_busy, exp_done, exp_plot}) begin
            errors++;
            $display("FAIL %s ctrl j=%0d busy/done/plot got %b%b%b want %b%b%b",
                     name, j, bus.busy, bus.done, bus.plot, exp_busy, exp_done, exp_plot);
         end
         checks++;
         if (bus.VGA_X !== 8'(ex) || bus.VGA_Y !== 7'(ey) || bus.VGA_COLOR !== 3'(ec)) begin
            errors++;
            $display("FAIL %s pixel j=%0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     name, j, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, ex, ey, ec);
         end
         if (j < N) begin
            checks++;
            if (bus.rom_addr !== 10'((s * N + j) % DEPTH)) begin
               errors++;
               $display("FAIL %s rom_addr j=%0d got %0d want %0d",
                        name, j, bus.rom_addr, (s * N + j) % DEPTH);
            end
         end
         if (bus.plot === 1'b1) plots++;
         if (bus.busy === 1'b1) busy_cyc++;
         if (poke) bus.start = (j == 50 || j == N + 2);
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      bus.start  = 1'b0; bus.sel  = '0; bus.x0  = '0; bus.y0  = '0;
      bus2.start = 1'b0; bus2.sel = '0; bus2.x0 = '0; bus2.y0 = '0;
`ifdef SPRITE_BLITTER_ERASE_EN
      bus.erase = 1'b0; bus2.erase = 1'b0;
`endif
      resetn = 1'b0;
      repeat (3) tick();
      for (int p = 0; p < 2; p++) begin
         checks++;
         if ({bus.rom_addr, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, bus.plot, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs phase=%0d got addr=%0d x=%0d y=%0d c=%0d plot=%b busy=%b done=%b want all 0",
                     p, bus.rom_addr, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, bus.plot, bus.busy, bus.done);
         end
         checks++;
         if ({bus2.rom_addr, bus2.VGA_X, bus2.VGA_Y, bus2.VGA_COLOR, bus2.plot, bus2.busy, bus2.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_2x2 phase=%0d got plot=%b busy=%b done=%b x=%0d want all 0",
                     p, bus2.plot, bus2.busy, bus2.done, bus2.VGA_X);
         end
         resetn = 1'b1;
         tick();
      end
   endtask

   task automatic test_tiny();
      int  tx [4] = '{10, 11, 10, 11};
      int  ty [4] = '{20, 20, 21, 21};
      bit  exp_busy, exp_done, exp_plot;
      for (int a = 0; a < 16; a++) rom2[a] = RED;
      bus2.start = 1'b1;
      bus2.sel   = 2'(ARROW_U);
      bus2.x0    = 8'd10;
      bus2.y0    = 7'd20;
      tick();
      bus2.start = 1'b0;
      for (int j = 0; j <= 7; j++) begin
         if (j > 0) tick();
         exp_plot = (j >= 2 && j <= 5);
         exp_done = (j == 6);
         exp_busy = (j <= 5);
         checks++;
         if ({bus2.busy, bus2.done, bus2.plot} !== {exp_busy, exp_done, exp_plot}) begin
            errors++;
            $display("FAIL tiny ctrl j=%0d busy/done/plot got %b%b%b want %b%b%b",
                     j, bus2.busy, bus2.done, bus2.plot, exp_busy, exp_done, exp_plot);
         end
         if (exp_plot) begin
            checks++;
            if (bus2.VGA_X !== 8'(tx[j-2]) || bus2.VGA_Y !== 7'(ty[j-2]) || bus2.VGA_COLOR !== RED) begin
               errors++;
               $display("FAIL tiny pixel j=%0d got (%0d,%0d,c%0d) want (%0d,%0d,c4)",
                        j, bus2.VGA_X, bus2.VGA_Y, bus2.VGA_COLOR, tx[j-2], ty[j-2]);
            end
         end
      end
   endtask

   task automatic test_transparent();
      int plots, busy_cyc;
      for (int a = 0; a < DEPTH; a++) rom[a] = (a % 2 == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      run_blit("transparent", ARROW_L, 20, 30, 1'b0, 1'b0, plots, busy_cyc);
      checks++;
      if (plots !== 128) begin
         errors++;
         $display("FAIL transparent plot_count got %0d want 128", plots);
      end
      checks++;
      if (busy_cyc !== N + 2) begin
         errors++;
         $display("FAIL transparent busy_cycles got %0d want %0d", busy_cyc, N + 2);
      end
   endtask

   task automatic test_clip();
      int plots, busy_cyc;
      for (int a = 0; a < DEPTH; a++) rom[a] = 3'($urandom_range(1, 7));
      run_blit("clip", ARROW_R, 150, 110, 1'b0, 1'b0, plots, busy_cyc);
      checks++;
      if (plots !== 100) begin
         errors++;
         $display("FAIL clip plot_count got %0d want 100", plots);
      end
   endtask

   task automatic test_random();
      int plots, busy_cyc;
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < DEPTH; a++) rom[a] = 3'($urandom_range(0, 7));
         run_blit("random", int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 127)), 1'b0, 1'b0, plots, busy_cyc);
      end
   endtask

   task automatic test_back_to_back();
      int plots, busy_cyc;
      for (int a = 0; a < DEPTH; a++) rom[a] = 3'($urandom_range(0, 7));
      run_blit("b2b_first", ARROW_D, 40, 50, 1'b0, 1'b1, plots, busy_cyc);
      run_blit("b2b_second", ARROW_U, 70, 10, 1'b0, 1'b0, plots, busy_cyc);
   endtask

   task automatic test_mid_reset();
      int plots, busy_cyc, done_seen, busy_seen;
      for (int a = 0; a < DEPTH; a++) rom[a] = 3'($urandom_range(1, 7));
      bus.start = 1'b1;
      bus.sel   = 2'(ARROW_D);
      bus.x0    = 8'd30;
      bus.y0    = 7'd40;
      tick();
      bus.start = 1'b0;
      repeat (52) tick();
      checks++;
      if (bus.plot !== 1'b1 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL midreset pre_state plot=%b busy=%b want 1 1", bus.plot, bus.busy);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({bus.rom_addr, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, bus.plot, bus.busy, bus.done} !== '0) begin
         errors++;
         $display("FAIL midreset async_clear got addr=%0d x=%0d y=%0d c=%0d plot=%b busy=%b done=%b want all 0",
                  bus.rom_addr, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, bus.plot, bus.busy, bus.done);
      end
      ex = 0; ey = 0; ec = 0;
      tick();
      resetn = 1'b1;
      done_seen = 0;
      busy_seen = 0;
      for (int j = 0; j < N + 6; j++) begin
         tick();
         if (bus.done === 1'b1) done_seen++;
         if (bus.busy === 1'b1) busy_seen++;
      end
      checks++;
      if (done_seen !== 0 || busy_seen !== 0) begin
         errors++;
         $display("FAIL midreset no_done got done_cycles=%0d busy_cycles=%0d want 0 0", done_seen, busy_seen);
      end
      run_blit("after_reset", ARROW_L, 5, 7, 1'b0, 1'b0, plots, busy_cyc);
      checks++;
      if (plots !== N) begin
         errors++;
         $display("FAIL after_reset plot_count got %0d want %0d", plots, N);
      end
   endtask

`ifdef SPRITE_BLITTER_ERASE_EN
   task automatic test_erase();
      int plots, busy_cyc;
      for (int a = 0; a < DEPTH; a++) rom[a] = 3'($urandom_range(0, 7));
      run_blit("erase", ARROW_R, 0, 0, 1'b1, 1'b0, plots, busy_cyc);
      checks++;
      if (plots !== N) begin
         errors++;
         $display("FAIL erase plot_count got %0d want %0d", plots, N);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_tiny();
      test_transparent();
      test_clip();
      test_random();
      test_back_to_back();
      test_mid_reset();
`ifdef SPRITE_BLITTER_ERASE_EN
      test_erase();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Upstream pixel source for the vga_adapter frame buffer (160x120, 3-bit colour). It drives the adapter's x/y/colour/plot inputs.
- On a start pulse it rasters one SPR_W x SPR_H sprite from an external synchronous sprite ROM to a screen position. Sprites are the four arrows and the countdown digits drawn over the static backgrounds.
- It skips transparent pixels, clips at screen edges, and reports busy/done to the game controller.

Parameters:
- SPR_W, 16, sprite width in pixels.
- SPR_H, 16, sprite height in pixels.
- NUM_SPR, 4, number of sprites stored back-to-back in the ROM.
- TRANSPARENT, 3'b000, ROM colour value that is never plotted.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- sel  in  clog2(NUM_SPR)  sprite index, latched on start.
- x0  in  8  top-left x, latched on start.
- y0  in  7  top-left y, latched on start.
- rom_addr  out  clog2(NUM_SPR*SPR_W*SPR_H)  sprite ROM address.
- rom_data  in  3  ROM pixel; valid one cycle after rom_addr.
- VGA_X  out  8  pixel x to the adapter.
- VGA_Y  out  7  pixel y to the adapter.
- VGA_COLOR  out  3  pixel colour to the adapter.
- plot  out  1  adapter write strobe.
- busy  out  1  high while a blit is in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is asynchronous, active-low (resetn).
- Reset values: every output is 0; state is IDLE; col/row counters are 0.
- States: IDLE, DRAW, FLUSH, DONE.
- Pixel order: row-major. Pixel index i = row*SPR_W + col. rom_addr = sel*SPR_W*SPR_H + i.
- IDLE -> DRAW: on the edge k where start=1, latch sel/x0/y0. rom_addr becomes the base address, busy goes to 1, counters clear.
- DRAW: one address per cycle. col wraps SPR_W-1 -> 0 and increments row. After issuing the last index (N = SPR_W*SPR_H), go to FLUSH.
- Pipeline: col/row delayed one stage to align with rom_data.
- Output register: VGA_X/VGA_Y/VGA_COLOR/plot are registered at the second stage.
- Pixel timing: pixel i appears after edge k+2+i. The last pixel appears after edge k+1+N.
- FLUSH: lasts 1 cycle, to drain the pipeline. Then DONE.
- DONE: done=1 for exactly one cycle (after edge k+2+N). busy falls on the same edge, then the block returns to IDLE.
- Coordinates: px = x0+col computed 9 bits wide; py = y0+row computed 8 bits wide. VGA_X/VGA_Y are the truncated values.
- plot = 1 only if rom_data != TRANSPARENT AND px < 160 AND py < 120. Clipped pixels still take a cycle, so timing is fixed.
- When plot=0, VGA_X/VGA_Y/VGA_COLOR hold their last plotted values.
- start while busy: ignored; no queueing.
- start in the same cycle as done: ignored. A new start is accepted in IDLE on the next cycle.
- sel >= NUM_SPR: address arithmetic wraps modulo ROM depth. No error is raised.
- Reset mid-blit: outputs clear immediately (asynchronous). No done pulse is produced.

Optional Feature:
- Macro: SPRITE_BLITTER_ERASE_EN.
- With the macro: adds input port erase (1 bit), latched on start.
  - When the latched erase=1, every in-bounds pixel is plotted with colour 3'b000, including transparent ones. This erases a sprite's bounding box.
  - ROM reads and timing are unchanged.
- Without the macro: no erase port; normal blit only.

Decomposition:
- Shared package dance_vga_pkg holds:
  - SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=3.
  - Colour constants (BLACK..WHITE).
  - Sprite index constants: ARROW_L/U/D/R.
  - The blitter state enum.
- One sub-module is natural: blit_raster_counter. It is the col/row counter with wrap, a last-pixel flag, and a linear index output.

Test Plan:
- Sprite of 2x2 all colour 3'b100 (for this test, SPR_W=SPR_H=2), start with x0=10, y0=20 at edge k:
  - plot after edges k+2..k+5 at (10,20),(11,20),(10,21),(11,21), colour 3'b100.
  - done after edge k+6.
- Default 16x16, ROM with TRANSPARENT at even indices: plot is high on exactly 128 cycles; busy is high for N+2 = 258 cycles.
- Clipping: x0=150, y0=110, opaque sprite -> exactly 100 plots (10x10 region). No plot has px>=160 or py>=120.
- start pulses mid-blit and again coincident with done -> both ignored. A start one cycle after done begins a new blit with newly latched sel.
- resetn low at the 50th pixel -> all outputs read 0 in the same cycle, no done pulse, state is IDLE. A start after release behaves normally.
- With SPRITE_BLITTER_ERASE_EN, erase=1, x0=0, y0=0 -> 256 plots, all colour 3'b000, regardless of ROM contents.
